// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Produces the pixel/line counters that drive a combinational painter, the
// visible-area enable, line/frame start pulses, and a registered, blanked
// connector stage (colour + syncs) that lags the counters by one clock.
module vga_timing #(
  parameter int H_RES    = 640,  // active pixels per line
  parameter int H_FP     = 16,   // horizontal front porch
  parameter int H_SYNC   = 96,   // hsync width
  parameter int H_BP     = 48,   // horizontal back porch
  parameter int V_RES    = 480,  // active lines per frame
  parameter int V_FP     = 10,   // vertical front porch
  parameter int V_SYNC   = 2,    // vsync width
  parameter int V_BP     = 33,   // vertical back porch
  parameter int SYNC_POL = 0     // sync active level (0 = active-low)
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic [3:0] paint_r,
  input  logic [3:0] paint_g,
  input  logic [3:0] paint_b,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       de,
  output logic       line,
  output logic       frame,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  // Raster geometry.
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // Counter-width copies of the decode boundaries, so every compare is 10-bit.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_RES);
  localparam logic [9:0] V_ACT    = 10'(V_RES);
  localparam logic [9:0] HS_FIRST = 10'(H_RES + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_RES + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_RES + V_FP + V_SYNC - 1);

  // Sync levels at the connector.
  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = (SYNC_POL == 0);

  logic h_end;   // last pixel of the line
  logic v_end;   // last line of the frame
  logic hs_act;  // sx inside the hsync window
  logic vs_act;  // sy inside the vsync window (whole lines)

  // Wrap detection uses >= so a counter can never stick outside the raster.
  assign h_end = (sx >= H_LAST);
  assign v_end = (sy >= V_LAST);

  // Pixel and line counters: sx every clock, sy only when sx wraps.
  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // reset in the sensitivity list, so every register clears the instant
  // rst_pix rises rather than waiting for the next pixel clock.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx <= '0;
      sy <= '0;
    end else if (h_end) begin
      sx <= '0;
      sy <= v_end ? '0 : sy + 10'd1;
    end else begin
      sx <= sx + 10'd1;
    end
  end

  // Combinational decode of the registered counters.
  always_comb begin
    de     = (sx < H_ACT) && (sy < V_ACT);
    line   = !rst_pix && (sx == '0);
    frame  = !rst_pix && (sx == '0) && (sy == '0);
    hs_act = (sx >= HS_FIRST) && (sx <= HS_LAST);
    vs_act = (sy >= VS_FIRST) && (sy <= VS_LAST);
  end

  // Connector stage: colour blanked outside the visible area, syncs from the
  // same-cycle decode, so all connector pins stay aligned one clock behind sx/sy.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      vga_hsync <= SYNC_OFF;
      vga_vsync <= SYNC_OFF;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else begin
      vga_hsync <= hs_act ? SYNC_ON : SYNC_OFF;
      vga_vsync <= vs_act ? SYNC_ON : SYNC_OFF;
      vga_r     <= de ? paint_r : '0;
      vga_g     <= de ? paint_g : '0;
      vga_b     <= de ? paint_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing.
// Two instances share clock, reset and painter inputs: one with the default
// 640x480 geometry (line-level behaviour) and one with a tiny raster and
// active-high syncs so several whole frames fit in a short run.
// Expected values come from plain arithmetic on the elapsed clock count.
module tb_vga_timing;

  typedef struct {
    int hr, hfp, hs, hbp;
    int vr, vfp, vs, vbp;
    bit pol;
  } geom_t;

  typedef struct {
    int sx, sy;
    bit de, line, frame, hs, vs;
  } exp_t;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic [3:0] pr, pg, pb;

  logic [9:0] s_sx, s_sy, d_sx, d_sy;
  logic       s_de, s_line, s_frame, s_hs, s_vs;
  logic       d_de, d_line, d_frame, d_hs, d_vs;
  logic [3:0] s_r, s_g, s_b, d_r, d_g, d_b;

  vga_timing #(
    .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_RES(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1)
  ) dut_s (
    .clk_pix(clk_pix), .rst_pix(rst_pix),
    .paint_r(pr), .paint_g(pg), .paint_b(pb),
    .sx(s_sx), .sy(s_sy), .de(s_de), .line(s_line), .frame(s_frame),
    .vga_hsync(s_hs), .vga_vsync(s_vs),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  vga_timing dut_d (
    .clk_pix(clk_pix), .rst_pix(rst_pix),
    .paint_r(pr), .paint_g(pg), .paint_b(pb),
    .sx(d_sx), .sy(d_sy), .de(d_de), .line(d_line), .frame(d_frame),
    .vga_hsync(d_hs), .vga_vsync(d_vs),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
  );

  always #5 clk_pix = ~clk_pix;

  geom_t       gs, gd;
  int          checks = 0;
  int          errors = 0;
  int          t;           // clocks since last reset release
  bit          hp;          // a previous post-release cycle exists
  exp_t        ps, pd;      // previous-cycle expectations
  logic [11:0] pp;          // previous-cycle painter colour
  int          last_frame_s, last_line_d;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  // Ideal raster position after t clocks, from the geometry alone.
  function automatic exp_t model(input geom_t g, input int tc);
    exp_t m;
    int ht, vt, hs0, vs0;
    ht  = g.hr + g.hfp + g.hs + g.hbp;
    vt  = g.vr + g.vfp + g.vs + g.vbp;
    hs0 = g.hr + g.hfp;
    vs0 = g.vr + g.vfp;
    m.sx    = tc % ht;
    m.sy    = (tc / ht) % vt;
    m.de    = (m.sx < g.hr) && (m.sy < g.vr);
    m.line  = (m.sx == 0);
    m.frame = (m.sx == 0) && (m.sy == 0);
    m.hs    = (m.sx >= hs0 && m.sx < hs0 + g.hs) ? g.pol : !g.pol;
    m.vs    = (m.sy >= vs0 && m.sy < vs0 + g.vs) ? g.pol : !g.pol;
    return m;
  endfunction

  task automatic check_inst(input string n, input geom_t g, input exp_t pv,
                            input int osx, input int osy, input bit ode,
                            input bit oline, input bit oframe, input bit ohs,
                            input bit ovs, input int orr, input int og, input int ob);
    exp_t m;
    m = model(g, t);
    check({n, ".sx"},    osx,    m.sx);
    check({n, ".sy"},    osy,    m.sy);
    check({n, ".de"},    ode,    m.de);
    check({n, ".line"},  oline,  m.line);
    check({n, ".frame"}, oframe, m.frame);
    if (hp) begin
      check({n, ".hsync"}, ohs, pv.hs);
      check({n, ".vsync"}, ovs, pv.vs);
      check({n, ".r"}, orr, pv.de ? int'(pp[11:8]) : 0);
      check({n, ".g"}, og,  pv.de ? int'(pp[7:4])  : 0);
      check({n, ".b"}, ob,  pv.de ? int'(pp[3:0])  : 0);
    end else begin
      check({n, ".hsync0"}, ohs, !g.pol);
      check({n, ".vsync0"}, ovs, !g.pol);
      check({n, ".rgb0"},   {orr, og, ob} == 0 ? 0 : 1, 0);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".s.sxsy"},  int'(s_sx) + int'(s_sy), 0);
    check({tag, ".s.pulse"}, {s_line, s_frame}, 0);
    check({tag, ".s.hsync"}, s_hs, !gs.pol);
    check({tag, ".s.vsync"}, s_vs, !gs.pol);
    check({tag, ".s.rgb"},   {s_r, s_g, s_b}, 0);
    check({tag, ".d.sxsy"},  int'(d_sx) + int'(d_sy), 0);
    check({tag, ".d.pulse"}, {d_line, d_frame}, 0);
    check({tag, ".d.hsync"}, d_hs, !gd.pol);
    check({tag, ".d.vsync"}, d_vs, !gd.pol);
    check({tag, ".d.rgb"},   {d_r, d_g, d_b}, 0);
  endtask

  task automatic check_all();
    check_inst("s", gs, ps, s_sx, s_sy, s_de, s_line, s_frame, s_hs, s_vs, s_r, s_g, s_b);
    check_inst("d", gd, pd, d_sx, d_sy, d_de, d_line, d_frame, d_hs, d_vs, d_r, d_g, d_b);
    if (s_frame) begin
      if (last_frame_s >= 0) check("s.frame_period", t - last_frame_s, 25 * 14);
      last_frame_s = t;
    end
    if (d_line) begin
      if (last_line_d >= 0) check("d.line_period", t - last_line_d, 800);
      last_line_d = t;
    end
  endtask

  task automatic release_reset();
    rst_pix      = 1'b0;
    #1;
    t            = 0;
    hp           = 1'b0;
    last_frame_s = -1;
    last_line_d  = -1;
  endtask

  // Each iteration checks the current cycle, records what the connector must
  // show next, lets one clock pass and presents a new random painter colour.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check_all();
      ps = model(gs, t);
      pd = model(gd, t);
      pp = {pr, pg, pb};
      hp = 1'b1;
      @(posedge clk_pix);
      #1;
      t++;
      pr = 4'($urandom);
      pg = 4'($urandom);
      pb = 4'($urandom);
      @(negedge clk_pix);
    end
  endtask

  // Reset raised between edges must clear everything before the next edge.
  task automatic mid_reset(input int hold);
    @(posedge clk_pix);
    #2;
    rst_pix = 1'b1;
    #1;
    check_reset("async");
    repeat (hold) @(posedge clk_pix);
    @(negedge clk_pix);
    check_reset("held");
    release_reset();
  endtask

  initial begin
    gs = '{16, 2, 3, 4, 8, 1, 2, 3, 1'b1};
    gd = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    pr = 4'hF; pg = 4'hA; pb = 4'h5;
    rst_pix = 1'b1;
    repeat (5) @(posedge clk_pix);
    @(negedge clk_pix);
    check_reset("hold");
    release_reset();
    run(1700);
    for (int k = 0; k < 3; k++) begin
      mid_reset($urandom_range(1, 4));
      run($urandom_range(300, 700));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

endmodule
